// File: rtl/contador_modn_updown.sv
// Modulo-MOD up/down digit counter with range-checked load and a sticky load-error flag.
// Optional: define CONTADOR_MODN_SATURATE_EN to add the sat input (stop at terminal value).
module contador_modn_updown #(
  parameter int MOD   = 6,
  parameter int WIDTH = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             clearn,
  input  logic             loadn,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
`ifdef CONTADOR_MODN_SATURATE_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             max,
  output logic             tc,
  output logic             err
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_step;
  logic             r_err;
  logic             w_err_nxt;
  logic             w_in_range;
  logic             w_zero;
  logic             w_max;
  logic             w_at_term;
  logic             w_hold_term;

  assign w_zero    = (r_count == '0);
  assign w_max     = (r_count == LP_MAX);
  assign w_at_term = up ? w_max : w_zero;

  // Widened by one bit so MOD == 2**WIDTH (every code legal) still compares correctly.
  assign w_in_range = ({1'b0, data} < (WIDTH+1)'(MOD));

`ifdef CONTADOR_MODN_SATURATE_EN
  assign w_hold_term = sat & w_at_term;
`else
  assign w_hold_term = 1'b0;
`endif

  always_comb begin
    w_step = r_count;
    if (up) begin
      w_step = w_max ? '0 : (r_count + WIDTH'(1));
    end else begin
      w_step = w_zero ? LP_MAX : (r_count - WIDTH'(1));
    end
  end

  // Load beats count; an out-of-range load clamps to MOD-1 and latches err.
  always_comb begin
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    if (!loadn) begin
      if (w_in_range) begin
        w_count_nxt = data;
      end else begin
        w_count_nxt = LP_MAX;
        w_err_nxt   = 1'b1;
      end
    end else if (en && !w_hold_term) begin
      w_count_nxt = w_step;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // tc is combinational so a rippled cascade advances the next digit on the same edge.
  assign count = r_count;
  assign zero  = w_zero;
  assign max   = w_max;
  assign tc    = en & w_at_term;
  assign err   = r_err;

endmodule

// File: tb/tb_contador_modn_updown.sv
// Self-checking bench for contador_modn_updown: a MOD=6 and a MOD=10 instance,
// directed sequences plus random stimulus checked against a modular-arithmetic model.
module tb_contador_modn_updown;

`ifdef CONTADOR_MODN_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       clearn = 1'b0;

  logic       loadn6 = 1'b1;
  logic [2:0] data6  = '0;
  logic       en6    = 1'b0;
  logic       up6    = 1'b0;
  logic       sat6   = 1'b0;
  logic [2:0] count6;
  logic       zero6, max6, tc6, err6;

  logic       loadn10 = 1'b1;
  logic [3:0] data10  = '0;
  logic       en10    = 1'b0;
  logic       up10    = 1'b0;
  logic       sat10   = 1'b0;
  logic [3:0] count10;
  logic       zero10, max10, tc10, err10;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [4:0] exp_q[$];
  int         m_cnt[2];
  logic       m_err[2];

  int dn_exp[4] = '{1, 0, 5, 4};
  int up_exp[4] = '{8, 9, 0, 1};

  contador_modn_updown #(.MOD(6)) u_dig6 (
    .clk    (clk),
    .clearn (clearn),
    .loadn  (loadn6),
    .data   (data6),
    .en     (en6),
    .up     (up6),
`ifdef CONTADOR_MODN_SATURATE_EN
    .sat    (sat6),
`endif
    .count  (count6),
    .zero   (zero6),
    .max    (max6),
    .tc     (tc6),
    .err    (err6)
  );

  contador_modn_updown #(.MOD(10)) u_dig10 (
    .clk    (clk),
    .clearn (clearn),
    .loadn  (loadn10),
    .data   (data10),
    .en     (en10),
    .up     (up10),
`ifdef CONTADOR_MODN_SATURATE_EN
    .sat    (sat10),
`endif
    .count  (count10),
    .zero   (zero10),
    .max    (max10),
    .tc     (tc10),
    .err    (err10)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // driver: the unselected digit is held (loadn=1, en=0)
  task automatic drive(input int sel, input logic ld_n, input int d,
                       input logic e, input logic u, input logic s);
    loadn6 = 1'b1; en6 = 1'b0; loadn10 = 1'b1; en10 = 1'b0;
    if (sel == 0) begin
      loadn6 = ld_n; data6 = 3'(d); en6 = e; up6 = u; sat6 = s;
    end else begin
      loadn10 = ld_n; data10 = 4'(d); en10 = e; up10 = u; sat10 = s;
    end
  endtask

  task automatic check_flags(input int sel, input logic e, input logic u);
    int   mod;
    int   c;
    logic z, mx, t;
    mod = (sel != 0) ? 10 : 6;
    c   = m_cnt[sel];
    z   = (c == 0);
    mx  = (c == mod - 1);
    t   = e & (u ? mx : z);
    if (sel == 0) begin
      check("zero6", int'(zero6), int'(z));
      check("max6",  int'(max6),  int'(mx));
      check("tc6",   int'(tc6),   int'(t));
    end else begin
      check("zero10", int'(zero10), int'(z));
      check("max10",  int'(max10),  int'(mx));
      check("tc10",   int'(tc10),   int'(t));
    end
  endtask

  // one clock of stimulus; the model result is queued, then popped after the edge
  task automatic step(input int sel, input logic ld_n, input int d,
                      input logic e, input logic u, input logic s);
    int         mod;
    int         c;
    logic       er;
    logic [4:0] got;
    logic [4:0] want;
    mod = (sel != 0) ? 10 : 6;
    drive(sel, ld_n, d, e, u, s);
    c  = m_cnt[sel];
    er = m_err[sel];
    if (!ld_n) begin
      if (d < mod) c = d;
      else begin
        c  = mod - 1;
        er = 1'b1;
      end
    end else if (e && !(SAT_EN && s && (u ? (c == mod - 1) : (c == 0)))) begin
      c = u ? ((c + 1) % mod) : ((c + mod - 1) % mod);
    end
    m_cnt[sel] = c;
    m_err[sel] = er;
    exp_q.push_back({er, 4'(c)});
    @(posedge clk);
    #1;
    want = exp_q.pop_front();
    got  = (sel != 0) ? {err10, count10} : {err6, 1'b0, count6};
    check(sel != 0 ? "count10" : "count6", int'(got[3:0]), int'(want[3:0]));
    check(sel != 0 ? "err10" : "err6", int'(got[4]), int'(want[4]));
    check_flags(sel, e, u);
  endtask

  task automatic model_reset();
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_err[0] = 1'b0; m_err[1] = 1'b0;
  endtask

  initial begin
    model_reset();
    // reset held across edges with en=1, up=0: must stay at 0 rather than wrap
    en6 = 1'b1; up6 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count6", int'(count6), 0);
    check("rst_zero6",  int'(zero6), 1);
    check("rst_max6",   int'(max6), 0);
    check("rst_tc6",    int'(tc6), 1);
    check("rst_err6",   int'(err6), 0);
    check("rst_count10", int'(count10), 0);
    check("rst_tc10",   int'(tc10), 0);
    en6 = 1'b0;
    clearn = 1'b1;

    // six-state digit counting down from 2: 2,1,0,5,4
    step(0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    check("dn_load", int'(count6), 2);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
      check("dn_seq", int'(count6), dn_exp[i]);
      check("dn_tc", int'(tc6), (dn_exp[i] == 0) ? 1 : 0);
    end

    // ten-state digit counting up from 7: 7,8,9,0,1
    step(1, 1'b0, 7, 1'b0, 1'b1, 1'b0);
    check("up_load", int'(count10), 7);
    for (int i = 0; i < 4; i++) begin
      step(1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
      check("up_seq", int'(count10), up_exp[i]);
      check("up_tc",  int'(tc10),  (up_exp[i] == 9) ? 1 : 0);
      check("up_max", int'(max10), (up_exp[i] == 9) ? 1 : 0);
    end

    // out-of-range load clamps and sets sticky err
    step(0, 1'b0, 7, 1'b0, 1'b0, 1'b0);
    check("clamp_count", int'(count6), 5);
    check("clamp_err", int'(err6), 1);
    step(0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    check("reload_count", int'(count6), 3);
    check("sticky_err", int'(err6), 1);
    step(0, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    check("hold_count", int'(count6), 3);

    // asynchronous clear mid-cycle, no clock edge involved
    #2;
    clearn = 1'b0;
    #1;
    check("aclr_count", int'(count6), 0);
    check("aclr_zero",  int'(zero6), 1);
    check("aclr_err",   int'(err6), 0);
    model_reset();
    clearn = 1'b1;

    // load beats enable, then one up edge
    step(0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    check("ld_en_count", int'(count6), 4);
    step(0, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    check("dir_up_count", int'(count6), 5);

`ifdef CONTADOR_MODN_SATURATE_EN
    // saturate at 0 going down, then release with sat=0
    step(0, 1'b0, 1, 1'b0, 1'b0, 1'b1);
    check("sat_load", int'(count6), 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
      check("sat_hold", int'(count6), 0);
      check("sat_tc", int'(tc6), 1);
    end
    step(0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    check("sat_release", int'(count6), 5);
`endif

    // random mix on both digits
    for (int i = 0; i < 80; i++) begin
      int   sel;
      logic ld_n, e, u, s;
      int   d;
      sel  = $urandom_range(0, 1);
      ld_n = ($urandom_range(0, 7) != 0);
      d    = (sel != 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
      e    = ($urandom_range(0, 3) != 0);
      u    = 1'($urandom_range(0, 1));
      s    = 1'($urandom_range(0, 1));
      step(sel, ld_n, d, e, u, s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
